spi_slave_cpol1_cpha0: RTL and testbench

//   SPI slave, mode CPOL=1/CPHA=0: sck idles high, sample on falling (leading) edge, shift on rising edge.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_slave_cpol1_cpha0.sv | 159 +++++++++++++++
 tb/tb_spi_slave_cpol1_cpha0.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave
//
// Purpose: FSM state encoding, SPI word width and the idle levels that the
//   input synchronisers are preset to, so a reset produces no false edges.
// Ports: none (package).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1
  } state_t;

  localparam int SPI_WIDTH = 8;
  localparam int CTR_W     = $clog2(SPI_WIDTH);

  // Bus levels while no controller is talking: deselected, CPOL=1 clock high.
  localparam logic SS_IDLE   = 1'b1;
  localparam logic SCK_IDLE  = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detect
//
// Purpose: brings one asynchronous pad signal into the clk domain through
//   STAGES flops, then compares against one further flop to flag edges.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset; chain preset to INIT
//   din   in  asynchronous input
//   sync  out synchronised level
//   rise  out 1-clk pulse on a synchronised 0->1 transition
//   fall  out 1-clk pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = ~prev & sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/spi_slave_cpol1_cpha0.sv
// rtl/spi_slave_cpol1_cpha0.sv - SPI slave, mode 2 (CPOL=1, CPHA=0)
//
// Purpose: oversamples ss_n/sck/mosi in the clk domain, samples MOSI on sck
//   falling edges into parallel bytes and shifts a parallel tx byte onto MISO
//   on rising edges. Full duplex, MSB first, back-to-back bytes while selected.
// Ports:
//   clk       in  system clock, at least 4x sck
//   rst       in  synchronous active-high reset
//   ss_n      in  slave select, active low (async)
//   sck       in  SPI clock, idles high (async)
//   mosi      in  serial data in (async)
//   miso      out serial data out, 1 when deselected
//   miso_oe   out MISO pad enable, 1 while selected
//   tx_data   in  next byte to transmit, captured at load points
//   tx_load   out 1-clk pulse: tx_data captured, may now change
//   rx_data   out last complete received byte
//   rx_valid  out 1-clk pulse: rx_data updated
//   busy      out 1 while a transfer is in progress
module spi_slave_cpol1_cpha0 import spi_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss_n,
  input  logic                 sck,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic [SPI_WIDTH-1:0] tx_data,
  output logic                 tx_load,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy
);

  logic ss_sync_unused, ss_rise, ss_fall;
  logic sck_sync_unused, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(SS_IDLE)) u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (ss_n),
    .sync (ss_sync_unused),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(SCK_IDLE)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .sync (sck_sync_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // mosi travels through the same depth as sck so the sampled bit lines up
  // with the detected falling edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(MOSI_IDLE)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .sync (mosi_sync),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  state_t               state_q, state_d;
  logic [CTR_W-1:0]     bit_ctr_q, bit_ctr_d;
  logic [SPI_WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [SPI_WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic                 miso_d, miso_oe_d, tx_load_d, rx_valid_d;
  logic [SPI_WIDTH-1:0] rx_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_ctr_q  <= '0;
      shift_rx_q <= '0;
      shift_tx_q <= '0;
      miso       <= 1'b1;
      miso_oe    <= 1'b0;
      tx_load    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_ctr_q  <= bit_ctr_d;
      shift_rx_q <= shift_rx_d;
      shift_tx_q <= shift_tx_d;
      miso       <= miso_d;
      miso_oe    <= miso_oe_d;
      tx_load    <= tx_load_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_ctr_d  = bit_ctr_q;
    shift_rx_d = shift_rx_q;
    shift_tx_d = shift_tx_q;
    miso_d     = miso;
    miso_oe_d  = miso_oe;
    rx_data_d  = rx_data;
    tx_load_d  = 1'b0;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_oe_d = 1'b0;
        miso_d    = 1'b1;
        // CPHA=0: the first bit must be on MISO before the first sck fall.
        if (ss_fall) begin
          shift_tx_d = tx_data;
          miso_d     = tx_data[SPI_WIDTH-1];
          tx_load_d  = 1'b1;
          bit_ctr_d  = '0;
          miso_oe_d  = 1'b1;
          state_d    = XFER;
        end
      end

      XFER: begin
        if (ss_rise) begin
          // Deselect wins over any coincident sck edge; partial byte dropped.
          state_d   = IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b1;
          bit_ctr_d = '0;
        end else if (sck_fall) begin
          shift_rx_d = {shift_rx_q[SPI_WIDTH-2:0], mosi_sync};
          bit_ctr_d  = bit_ctr_q + CTR_W'(1);
          if (bit_ctr_q == CTR_W'(SPI_WIDTH - 1)) begin
            rx_data_d  = {shift_rx_q[SPI_WIDTH-2:0], mosi_sync};
            rx_valid_d = 1'b1;
          end
        end else if (sck_rise) begin
          if (bit_ctr_q != '0) begin
            shift_tx_d = shift_tx_q << 1;
            miso_d     = shift_tx_q[SPI_WIDTH-2];
          end else begin
            // Rise after the 8th fall: start the next byte for back-to-back use.
            shift_tx_d = tx_data;
            miso_d     = tx_data[SPI_WIDTH-1];
            tx_load_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == XFER);

endmodule

// File: tb/tb_spi_slave_cpol1_cpha0.sv
// tb/tb_spi_slave_cpol1_cpha0.sv - scoreboard bench for the mode-2 SPI slave
module tb_spi_slave_cpol1_cpha0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;

  // DUT with 2 sync stages, sck = clk/8
  logic       ss_n = 1'b1, sck = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_load, rx_valid, busy;
  logic [7:0] tx_data = 8'hA5;
  logic [7:0] rx_data;

  // DUT with 3 sync stages, sck = clk/4
  logic       ss_n3 = 1'b1, sck3 = 1'b1, mosi3 = 1'b0;
  logic       miso3, miso_oe3, tx_load3, rx_valid3, busy3;
  logic [7:0] tx_data3 = 8'h00;
  logic [7:0] rx_data3;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rx3[$];
  logic [7:0] tx_next[$];
  logic [7:0] send_q[$];
  int         fall_cyc[2];
  int         n_loads = 0;
  logic       oe_seen = 1'b0;
  logic [7:0] last_rx = 8'h00;
  logic       rx_valid_prev = 1'b0, tx_load_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_cpol1_cpha0 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  spi_slave_cpol1_cpha0 #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .ss_n(ss_n3), .sck(sck3), .mosi(mosi3),
    .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data3), .tx_load(tx_load3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sck(input bit sel, input logic v);
    if (sel) sck3 = v; else sck = v;
  endtask

  task automatic set_ss(input bit sel, input logic v);
    if (sel) ss_n3 = v; else ss_n = v;
  endtask

  task automatic set_mosi(input bit sel, input logic v);
    if (sel) mosi3 = v; else mosi = v;
  endtask

  function automatic logic get_miso(input bit sel);
    return sel ? miso3 : miso;
  endfunction

  // Mode-2 master: data set while sck high, both sides sample on the fall.
  task automatic spi_byte(input bit sel, input int h, input logic [7:0] b,
                          input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      set_mosi(sel, b[7-i]);
      clks(h);
      got = {got[6:0], get_miso(sel)};
      set_sck(sel, 1'b0);
      if (i == 7) fall_cyc[sel] = cyc;
      clks(h);
      set_sck(sel, 1'b1);
    end
  endtask

  // Sends send_q with ss held low; the final byte is cut to last_bits bits.
  task automatic run_burst(input bit sel, input int h, input int last_bits);
    logic [7:0] nx[$];
    logic [7:0] first, got, exp_m;
    int         loads0, nb, full;
    nx     = tx_next;
    first  = tx_data;
    loads0 = n_loads;
    full   = 0;
    set_ss(sel, 1'b0);
    clks(8);
    if (!sel) begin
      check("busy in xfer", busy, 1);
      check("miso_oe in xfer", miso_oe, 1);
    end
    for (int k = 0; k < send_q.size(); k++) begin
      nb = (k == send_q.size() - 1) ? last_bits : 8;
      if (nb == 8) begin
        full++;
        if (sel) exp_rx3.push_back(send_q[k]); else exp_rx.push_back(send_q[k]);
      end
      spi_byte(sel, h, send_q[k], nb, got);
      if (!sel && nb == 8) begin
        exp_m = (k == 0) ? first : nx[k-1];
        check($sformatf("miso byte %0d", k), got, exp_m);
      end
    end
    clks(8);
    set_ss(sel, 1'b1);
    clks(8);
    if (!sel) begin
      check("tx_load count", n_loads - loads0, 1 + full);
      check("busy after", busy, 0);
      check("miso_oe after", miso_oe, 0);
      check("miso after", miso, 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_valid unexpected", 1, 0);
        else begin
          check("rx_data", rx_data, exp_rx.pop_front());
          check("rx latency", cyc - fall_cyc[0], 3);
        end
        last_rx = rx_data;
        check("rx_valid width", rx_valid_prev, 0);
      end
      if (tx_load) begin
        n_loads++;
        check("tx_load width", tx_load_prev, 0);
        if (tx_next.size() != 0) tx_data = tx_next.pop_front();
      end
      if (rx_valid3) begin
        if (exp_rx3.size() == 0) check("rx_valid3 unexpected", 1, 0);
        else begin
          check("rx_data3", rx_data3, exp_rx3.pop_front());
          check("rx latency3", cyc - fall_cyc[1], 4);
        end
      end
      if (miso_oe) oe_seen = 1'b1;
    end
    rx_valid_prev = rx_valid;
    tx_load_prev  = tx_load;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    int         loads0, nbytes;

    clks(3);
    check("reset miso", miso, 1);
    check("reset miso_oe", miso_oe, 0);
    check("reset tx_load", tx_load, 0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    clks(4);

    // Single byte, tx A5
    send_q = '{8'h3C};
    tx_next = '{8'h77};
    run_burst(0, 4, 8);

    // Three back-to-back bytes
    tx_data = 8'hA5;
    send_q = '{8'h01, 8'h80, 8'hFF};
    tx_next = '{8'h11, 8'h22, 8'h33};
    run_burst(0, 4, 8);

    // Abort after 5 bits
    send_q = '{8'hC6};
    run_burst(0, 4, 5);
    check("rx_data held", rx_data, 8'hFF);

    // Reset mid-byte, bus returned to idle during reset
    set_ss(0, 1'b0);
    clks(8);
    spi_byte(0, 4, 8'hE7, 3, got);
    rst = 1'b1; ss_n = 1'b1; sck = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(2);
    check("rst rx_data", rx_data, 8'h00);
    check("rst busy", busy, 0);
    check("rst miso_oe", miso_oe, 0);
    check("rst miso", miso, 1);
    last_rx = 8'h00;
    send_q = '{8'h5A};
    tx_next = '{8'h9C};
    run_burst(0, 4, 8);

    // sck activity while deselected
    oe_seen = 1'b0;
    loads0 = n_loads;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sck = ~sck;
      clks(4);
    end
    sck = 1'b1;
    clks(8);
    check("idle tx_load", n_loads - loads0, 0);
    check("idle miso_oe", oe_seen, 0);
    check("idle rx_data", rx_data, 8'h5A);

    // Randomized bursts
    for (int r = 0; r < 6; r++) begin
      nbytes = $urandom_range(1, 4);
      send_q.delete();
      tx_next.delete();
      for (int k = 0; k < nbytes; k++) begin
        send_q.push_back(8'($urandom));
        tx_next.push_back(8'($urandom));
      end
      tx_data = 8'($urandom);
      run_burst(0, 4, 8);
    end

    // Deeper synchroniser, faster sck
    send_q = '{8'hC3};
    run_burst(1, 2, 8);

    clks(10);
    check("rx queue drained", exp_rx.size(), 0);
    check("rx3 queue drained", exp_rx3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
